mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle control sequencer for the I-type datapath: PC register, instruction memory, register file (rs/rt read, rt write) and ALU. It replaces single-cycle, combinational sequencing with a fetch/decode/execute/writeback FSM. It handshakes with an instruction memory that may stall, and gates register and PC writes. Branch resolution uses the ALU zero flag, and register writes are suppressed on ALU overflow.

## Interface
- `TIMEOUT`, default 15: maximum cycles to wait for `imem_ready` before entering ERROR; 4-bit counter range.
- `HALT_OP`, default 6'b111111: opcode that stops the sequencer.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin execution from IDLE; ignored in all other states.
- `opcode` input 6: bits [31:26] of the instruction register.
- `zero` input 1: ALU zero flag, valid in EXECUTE.
- `overflow` input 1: ALU overflow flag, valid in EXECUTE.
- `imem_ready` input 1: instruction memory data valid.
- `imem_req` output 1: instruction fetch request.
- `ir_write` output 1: load the instruction register.
- `reg_write` output 1: register file write enable.
- `pc_write` output 1: PC load enable.
- `pc_src` output 1: 0 selects PC+4; 1 selects PC+4+(sext(imm)<<2).
- `busy` output 1: high in every state except IDLE, HALT and ERROR.
- `ovf_flag` output 1: sticky overflow indicator.
- `error` output 1: high in ERROR.
- `instr_count` output 16: count of retired instructions.

## Operation
- States are IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, BRANCH, HALT and ERROR.
- IDLE:
  - `start` moves the FSM to FETCH.
  - Entering FETCH from IDLE clears `ovf_flag` and `instr_count`.
- FETCH:
  - `imem_req`=1.
  - When `imem_ready`=1: `ir_write`=1 in the same cycle, then go to DECODE.
  - Otherwise the wait counter increments. When the counter reaches `TIMEOUT` without `imem_ready`, go to ERROR.
  - The wait counter clears on entry to FETCH.
- DECODE:
  - `opcode`==`HALT_OP`: go to HALT.
  - `opcode[3]`=1 (ALU-immediate class): go to EXECUTE, then WRITEBACK.
  - `opcode[3]`=0 (branch class): go to EXECUTE, then BRANCH.
  - A 1-bit class register latches `opcode[3]` in DECODE.
- EXECUTE:
  - One cycle, no write enables.
  - Latch `zero` and `overflow` into registers `z_q` and `v_q`.
- WRITEBACK:
  - `reg_write` = !`v_q`.
  - If `v_q` is set, `ovf_flag` is set.
  - `pc_write`=1, `pc_src`=0.
  - `instr_count`++.
  - Go to FETCH.
- BRANCH:
  - `pc_write`=1, `pc_src` = !`z_q` (taken when not zero).
  - `instr_count`++.
  - Go to FETCH.
- HALT and ERROR are terminal; only reset leaves them. All write enables are 0 in both.
- `instr_count` wraps from 16'hFFFF to 0 without a flag.
- An instruction that sets overflow still retires: it is counted and the PC advances.

## Timing
- Reset values:
  - State is IDLE.
  - All enables, `imem_req`, `busy`, `error` and `ovf_flag` are 0.
  - `instr_count` is 0.
  - Wait counter, `z_q` and `v_q` are 0.
- Output decoding:
  - Outputs are decoded from the state register only (Moore).
  - Exception: `ir_write` = (state==FETCH) & `imem_ready`.
- Latency:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK) with zero memory wait.
  - Branch: 4 cycles.
  - Each memory wait cycle adds one cycle.
- `imem_ready` arriving on the same cycle the counter hits `TIMEOUT`: ready wins, go to DECODE.
- `start` held high in HALT or ERROR has no effect.
- Reset asserted mid-instruction: immediate return to IDLE. No write enable may be high after `rst_n` falls, combinationally.

## Structure
- A shared package `mc_pkg` holds:
  - the state enum, with 3-bit encoding;
  - the `PC_SEQ`/`PC_BR` constants;
  - the opcode-class bit index (3).
- One sub-module, `fetch_timer`: the 4-bit wait counter with clear and expire output.
- The PC adder and sign-extend remain in the datapath; the sequencer produces control only.

## Test plan
- Reset, then `start`; ALU opcode 6'b001000; `imem_ready` tied 1; `zero`=0, `overflow`=0:
  - `reg_write` pulses exactly on cycle 4 with `pc_src`=0.
  - `instr_count`=1.
- Branch opcode 6'b000101 with `zero`=0:
  - BRANCH cycle shows `pc_write`=1, `pc_src`=1, `reg_write`=0.
  - Repeat with `zero`=1: `pc_src`=0.
- ALU opcode with `overflow`=1 in EXECUTE:
  - `reg_write`=0 and `pc_write`=1 in WRITEBACK.
  - `ovf_flag` goes to 1 and remains 1 through the next clean instruction.
- `imem_ready` delayed 3 cycles:
  - `imem_req` is held for 4 cycles.
  - `ir_write` is a single pulse on the 4th.
  - Total instruction latency is 7.
- `imem_ready` held 0:
  - ERROR is reached after `TIMEOUT`=15 wait cycles; `error`=1, `busy`=0.
  - `start` ignored; only `rst_n` recovers.
- Opcode `HALT_OP` after 2 instructions:
  - HALT with `instr_count`=2.
  - Separately, assert `rst_n`=0 during EXECUTE: all outputs 0 in the same cycle, then IDLE.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_BRANCH    = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  localparam logic PC_SEQ    = 1'b0;
  localparam logic PC_BR     = 1'b1;
  localparam int   CLASS_BIT = 3;
  localparam int   WAIT_W    = 4;

endpackage

// File: rtl/fetch_timer.sv
// Instruction-memory wait counter: counts stalled fetch cycles and flags
// expiry once the count equals TIMEOUT.
module fetch_timer
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !expire) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LIMIT);

endmodule

// File: rtl/mc_sequencer.sv
// Fetch/decode/execute/writeback control FSM for the I-type datapath; it
// drives enables only, the PC adder and sign-extend live in the datapath.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int         TIMEOUT = 15,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        overflow,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        busy,
  output logic        ovf_flag,
  output logic        error,
  output logic [15:0] instr_count
);

  state_t state;
  logic   cls_q;
  logic   z_q;
  logic   v_q;
  logic   in_fetch;
  logic   expire;

  assign in_fetch = (state == S_FETCH);

  // Held clear outside FETCH, so every FETCH entry starts counting from zero.
  fetch_timer #(.TIMEOUT(TIMEOUT)) u_fetch_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_fetch),
    .inc    (in_fetch && !imem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cls_q       <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      ovf_flag    <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_FETCH;
            ovf_flag    <= 1'b0;
            instr_count <= '0;
          end
        end
        S_FETCH: begin
          // A ready arriving in the expiry cycle still completes the fetch.
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (expire) begin
            state <= S_ERROR;
          end
        end
        S_DECODE: begin
          cls_q <= opcode[CLASS_BIT];
          state <= (opcode == HALT_OP) ? S_HALT : S_EXECUTE;
        end
        S_EXECUTE: begin
          z_q   <= zero;
          v_q   <= overflow;
          state <= cls_q ? S_WRITEBACK : S_BRANCH;
        end
        S_WRITEBACK: begin
          if (v_q) begin
            ovf_flag <= 1'b1;
          end
          instr_count <= instr_count + 16'd1;
          state       <= S_FETCH;
        end
        S_BRANCH: begin
          instr_count <= instr_count + 16'd1;
          state       <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        S_ERROR: state <= S_ERROR;
      endcase
    end
  end

  // Moore decode straight off the state register, so an asynchronous reset
  // drops every enable in the same instant the state returns to IDLE.
  always_comb begin
    imem_req  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SEQ;
    busy      = 1'b0;
    error     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
      end
      S_DECODE, S_EXECUTE: begin
        busy = 1'b1;
      end
      S_WRITEBACK: begin
        reg_write = !v_q;
        pc_write  = 1'b1;
        pc_src    = PC_SEQ;
        busy      = 1'b1;
      end
      S_BRANCH: begin
        pc_write = 1'b1;
        pc_src   = z_q ? PC_SEQ : PC_BR;
        busy     = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ir_write = in_fetch & imem_ready;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed scoreboard bench for mc_sequencer: each cycle pushes the expected
// output vector, which is popped and compared at the falling edge.
module tb_mc_sequencer;

  localparam logic [5:0] ALU_OP  = 6'b001000;
  localparam logic [5:0] BR_OP   = 6'b000101;
  localparam logic [5:0] HALT_OP = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        overflow = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic        ir_write;
  logic        reg_write;
  logic        pc_write;
  logic        pc_src;
  logic        busy;
  logic        ovf_flag;
  logic        error;
  logic [15:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [23:0] v;
  } exp_t;

  exp_t sb[$];

  wire [23:0] observed = {imem_req, ir_write, reg_write, pc_write, pc_src,
                          busy, ovf_flag, error, instr_count};

  mc_sequencer #(.TIMEOUT(15), .HALT_OP(HALT_OP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .zero        (zero),
    .overflow    (overflow),
    .imem_ready  (imem_ready),
    .imem_req    (imem_req),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .busy        (busy),
    .ovf_flag    (ovf_flag),
    .error       (error),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ev(input logic req, input logic irw,
                                     input logic rw, input logic pw,
                                     input logic src, input logic bsy,
                                     input logic ovf, input logic err,
                                     input logic [15:0] cnt);
    return {req, irw, rw, pw, src, bsy, ovf, err, cnt};
  endfunction

  function automatic logic [23:0] idleE();
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 16'd0);
  endfunction
  function automatic logic [23:0] fetchE(input logic ovf, input logic [15:0] cnt);
    return ev(1, 1, 0, 0, 0, 1, ovf, 0, cnt);
  endfunction
  function automatic logic [23:0] waitE(input logic ovf, input logic [15:0] cnt);
    return ev(1, 0, 0, 0, 0, 1, ovf, 0, cnt);
  endfunction
  function automatic logic [23:0] busyE(input logic ovf, input logic [15:0] cnt);
    return ev(0, 0, 0, 0, 0, 1, ovf, 0, cnt);
  endfunction
  function automatic logic [23:0] wbE(input logic rw, input logic ovf, input logic [15:0] cnt);
    return ev(0, 0, rw, 1, 0, 1, ovf, 0, cnt);
  endfunction
  function automatic logic [23:0] brE(input logic src, input logic ovf, input logic [15:0] cnt);
    return ev(0, 0, 0, 1, src, 1, ovf, 0, cnt);
  endfunction
  function automatic logic [23:0] haltE(input logic ovf, input logic [15:0] cnt);
    return ev(0, 0, 0, 0, 0, 0, ovf, 0, cnt);
  endfunction
  function automatic logic [23:0] errE(input logic ovf, input logic [15:0] cnt);
    return ev(0, 0, 0, 0, 0, 0, ovf, 1, cnt);
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
    end else begin
      e = sb.pop_front();
      vectors++;
      assert (observed === e.v) else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.v);
      end
    end
  endtask

  task automatic pushExp(input string tag, input logic [23:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  // One clock cycle: drive inputs just after the rising edge, check at the falling edge.
  task automatic applyStimulus(input string tag, input logic st, input logic [5:0] op,
                               input logic z, input logic v, input logic rdy,
                               input logic [23:0] expv);
    start      = st;
    opcode     = op;
    zero       = z;
    overflow   = v;
    imem_ready = rdy;
    pushExp(tag, expv);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait instruction; the ALU flags flip after EXECUTE to prove they are latched.
  task automatic runInstr(input string tag, input logic [5:0] op, input logic z,
                          input logic v, input logic ovf, input logic [15:0] cnt,
                          input logic [23:0] lastE);
    applyStimulus({tag, "_fetch"},  0, op, 0,  0,  1, fetchE(ovf, cnt));
    applyStimulus({tag, "_decode"}, 0, op, 0,  0,  1, busyE(ovf, cnt));
    applyStimulus({tag, "_exec"},   0, op, z,  v,  1, busyE(ovf, cnt));
    applyStimulus({tag, "_last"},   0, op, ~z, ~v, 1, lastE);
  endtask

  task automatic doReset(input string tag);
    rst_n      = 1'b0;
    start      = 1'b0;
    imem_ready = 1'b0;
    zero       = 1'b0;
    overflow   = 1'b0;
    pushExp(tag, idleE());
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reset dropped in the middle of a cycle must clear outputs without a clock edge.
  task automatic midReset(input string tag, input logic [23:0] preE);
    pushExp({tag, "_pre"}, preE);
    checkOutput();
    #1;
    rst_n = 1'b0;
    #1;
    pushExp({tag, "_rst"}, idleE());
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    doReset("reset0");
    applyStimulus("idle",  0, ALU_OP, 0, 0, 1, idleE());
    applyStimulus("start", 1, ALU_OP, 0, 0, 1, idleE());

    runInstr("alu",       ALU_OP, 0, 0, 0, 16'd0, wbE(1, 0, 16'd0));
    runInstr("br_nz",     BR_OP,  0, 0, 0, 16'd1, brE(1, 0, 16'd1));
    runInstr("br_z",      BR_OP,  1, 0, 0, 16'd2, brE(0, 0, 16'd2));
    runInstr("alu_ovf",   ALU_OP, 0, 1, 0, 16'd3, wbE(0, 0, 16'd3));
    runInstr("alu_clean", ALU_OP, 0, 0, 1, 16'd4, wbE(1, 1, 16'd4));

    for (int i = 0; i < 3; i++)
      applyStimulus("dly_wait", 0, ALU_OP, 0, 0, 0, waitE(1, 16'd5));
    runInstr("dly", ALU_OP, 0, 0, 1, 16'd5, wbE(1, 1, 16'd5));

    for (int i = 0; i < 15; i++)
      applyStimulus("late_wait", 0, BR_OP, 0, 0, 0, waitE(1, 16'd6));
    runInstr("late", BR_OP, 1, 0, 1, 16'd6, brE(0, 1, 16'd6));

    applyStimulus("h1_fetch",  0, HALT_OP, 0, 0, 1, fetchE(1, 16'd7));
    applyStimulus("h1_decode", 0, HALT_OP, 0, 0, 1, busyE(1, 16'd7));
    applyStimulus("h1_halt",   1, HALT_OP, 0, 0, 1, haltE(1, 16'd7));
    applyStimulus("h1_hold",   1, HALT_OP, 0, 0, 1, haltE(1, 16'd7));

    doReset("reset1");
    applyStimulus("h2_start", 1, ALU_OP, 0, 0, 1, idleE());
    runInstr("h2_alu", ALU_OP, 0, 0, 0, 16'd0, wbE(1, 0, 16'd0));
    runInstr("h2_br",  BR_OP,  0, 0, 0, 16'd1, brE(1, 0, 16'd1));
    applyStimulus("h2_fetch",  0, HALT_OP, 0, 0, 1, fetchE(0, 16'd2));
    applyStimulus("h2_decode", 0, HALT_OP, 0, 0, 1, busyE(0, 16'd2));
    applyStimulus("h2_halt",   1, HALT_OP, 0, 0, 1, haltE(0, 16'd2));
    applyStimulus("h2_hold",   1, ALU_OP,  0, 0, 1, haltE(0, 16'd2));

    doReset("reset2");
    applyStimulus("r_start",  1, ALU_OP, 0, 0, 1, idleE());
    applyStimulus("r_fetch",  0, ALU_OP, 0, 0, 1, fetchE(0, 16'd0));
    applyStimulus("r_decode", 0, ALU_OP, 0, 0, 1, busyE(0, 16'd0));
    midReset("r_exec", busyE(0, 16'd0));
    applyStimulus("r_idle",   0, ALU_OP, 0, 0, 1, idleE());
    applyStimulus("r2_start", 1, ALU_OP, 0, 0, 1, idleE());
    applyStimulus("r2_fetch", 0, ALU_OP, 0, 0, 1, fetchE(0, 16'd0));
    applyStimulus("r2_decode",0, ALU_OP, 0, 0, 1, busyE(0, 16'd0));
    applyStimulus("r2_exec",  0, ALU_OP, 0, 0, 1, busyE(0, 16'd0));
    midReset("r2_wb", wbE(1, 0, 16'd0));
    applyStimulus("r2_idle",  0, ALU_OP, 0, 0, 1, idleE());

    doReset("reset3");
    applyStimulus("e_start", 1, ALU_OP, 0, 0, 0, idleE());
    for (int i = 0; i < 16; i++)
      applyStimulus("e_wait", 0, ALU_OP, 0, 0, 0, waitE(0, 16'd0));
    applyStimulus("e_error",  0, ALU_OP, 0, 0, 0, errE(0, 16'd0));
    applyStimulus("e_start1", 1, ALU_OP, 0, 0, 1, errE(0, 16'd0));
    applyStimulus("e_start2", 1, ALU_OP, 0, 0, 1, errE(0, 16'd0));
    doReset("reset4");
    applyStimulus("e_idle", 0, ALU_OP, 0, 0, 0, idleE());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
